// File: rtl/lcd_receiver_if.sv
// Host-side bus of the character LCD receiver:
// strobe, register select, direction, payload and read response.
interface lcd_receiver_if;
  logic       E;
  logic       RS;
  logic       RW;
  logic [7:0] DATA;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;

  modport master (
    output E, RS, RW, DATA,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  E, RS, RW, DATA,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/lcd_receiver.sv
// Character LCD controller receiver: instruction decode,
// 80-byte DDRAM with per-byte valid bits, busy timing.
module lcd_receiver #(
  parameter int BUSY_SHORT = 0,
  parameter int BUSY_LONG  = 2
) (
  input  logic         clock,
  input  logic         reset,
  lcd_receiver_if.slave bus,
  input  logic [6:0]   view_addr,
  output logic [7:0]   view_char,
  output logic [6:0]   ac,
  output logic         display_on,
  output logic         cursor_on,
  output logic         blink_on,
  output logic         two_line,
  output logic         err
);

  function automatic logic in_range(input logic [6:0] a);
    return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
  endfunction

  // Line 2 packs directly after line 1 in storage.
  function automatic logic [6:0] slot(input logic [6:0] a);
    if (!in_range(a)) return 7'd0;
    return a[6] ? 7'd40 + {1'b0, a[5:0]} : a;
  endfunction

  function automatic logic [6:0] stepf(
    input logic [6:0] a,
    input logic       up
  );
    if (up) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h00) return 7'h67;
    if (a == 7'h40) return 7'h27;
    return a - 7'd1;
  endfunction

  logic [7:0]  mem [80];
  logic [79:0] vld;
  logic [7:0]  cnt, cnt_n;
  logic        id, id_n;
  logic [6:0]  ac_n;
  logic        disp_n, cur_n, blink_n, line_n, err_n;
  logic        clr, mem_we;
  logic [7:0]  lead;
  logic        busy_w, wr, rd, take;
  logic [6:0]  wslot, vslot;
  logic [7:0]  rd_byte, vw_byte;

  assign busy_w   = cnt != 8'd0;
  assign bus.busy = busy_w;
  assign wr       = bus.E & ~bus.RW;
  assign rd       = bus.E & bus.RW;
  assign take     = wr & ~busy_w;
  assign wslot    = slot(ac);
  assign vslot    = slot(view_addr);
  assign rd_byte  = vld[wslot] ? mem[wslot] : 8'h20;
  assign vw_byte  = (in_range(view_addr) && vld[vslot])
                  ? mem[vslot] : 8'h20;

  // One-hot of the most significant set bit of DATA.
  always_comb begin
    lead = 8'd0;
    for (int i = 0; i < 8; i++)
      if (bus.DATA[i]) lead = 8'd1 << i;
  end

  always_comb begin
    ac_n    = ac;
    id_n    = id;
    disp_n  = display_on;
    cur_n   = cursor_on;
    blink_n = blink_on;
    line_n  = two_line;
    err_n   = err | (wr & busy_w);
    cnt_n   = busy_w ? cnt - 8'd1 : cnt;
    clr     = 1'b0;
    mem_we  = 1'b0;
    if (take) begin
      cnt_n = 8'(BUSY_SHORT);
      if (bus.RS) begin
        mem_we = 1'b1;
        ac_n   = stepf(ac, id);
      end else begin
        unique case (1'b1)
          lead[7]:
            if (in_range(bus.DATA[6:0])) ac_n = bus.DATA[6:0];
            else err_n = 1'b1;
          lead[6]: err_n = 1'b1;
          lead[5]: line_n = bus.DATA[3];
          lead[4]:
            if (!bus.DATA[3]) ac_n = stepf(ac, bus.DATA[2]);
          lead[3]: begin
            disp_n  = bus.DATA[2];
            cur_n   = bus.DATA[1];
            blink_n = bus.DATA[0];
          end
          lead[2]: id_n = bus.DATA[1];
          lead[1]: begin
            ac_n  = 7'd0;
            cnt_n = 8'(BUSY_LONG);
          end
          lead[0]: begin
            clr   = 1'b1;
            ac_n  = 7'd0;
            id_n  = 1'b1;
            cnt_n = 8'(BUSY_LONG);
          end
          default: cnt_n = 8'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ac           <= 7'd0;
      id           <= 1'b1;
      cnt          <= 8'd0;
      display_on   <= 1'b0;
      cursor_on    <= 1'b0;
      blink_on     <= 1'b0;
      two_line     <= 1'b0;
      err          <= 1'b0;
      vld          <= '0;
      bus.rd_data  <= 8'h00;
      bus.rd_valid <= 1'b0;
      view_char    <= 8'h20;
    end else begin
      ac           <= ac_n;
      id           <= id_n;
      cnt          <= cnt_n;
      display_on   <= disp_n;
      cursor_on    <= cur_n;
      blink_on     <= blink_n;
      two_line     <= line_n;
      err          <= err_n;
      if (clr) vld <= '0;
      else if (mem_we) vld[wslot] <= 1'b1;
      bus.rd_valid <= rd;
      if (rd) bus.rd_data <= bus.RS ? rd_byte : {busy_w, ac};
      view_char    <= vw_byte;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && mem_we) mem[wslot] <= bus.DATA;
  end

endmodule

// File: tb/tb_lcd_receiver.sv
// Randomized scoreboard bench for lcd_receiver against
// a behavioural model of the controller rules.
module tb_lcd_receiver;
  localparam int BS = 0;
  localparam int BL = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] view_addr = 7'd0;
  logic [7:0] view_char;
  logic [6:0] ac;
  logic       display_on, cursor_on, blink_on, two_line, err;

  lcd_receiver_if bus ();

  lcd_receiver #(.BUSY_SHORT(BS), .BUSY_LONG(BL)) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus.slave),
    .view_addr  (view_addr),
    .view_char  (view_char),
    .ac         (ac),
    .display_on (display_on),
    .cursor_on  (cursor_on),
    .blink_on   (blink_on),
    .two_line   (two_line),
    .err        (err)
  );

  always #5 clock = ~clock;

  typedef struct {
    int ac; int busy; int err;
    int disp; int cur; int blink; int two;
    int view; int rdv; int rdh;
  } snap_t;

  snap_t sq[$];
  int    rdq[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  int mm[128];
  int m_ac, m_id, m_cnt, m_rd;
  int m_err, m_disp, m_cur, m_blink, m_two;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic int is_ddr(int a);
    return (a >= 0 && a <= 39) || (a >= 64 && a <= 103);
  endfunction

  function automatic int mbyte(int a);
    if (is_ddr(a) && mm[a] >= 0) return mm[a];
    return 32;
  endfunction

  function automatic int mstep(int a, int up);
    if (up != 0) begin
      if (a == 39) return 64;
      if (a == 103) return 0;
      return a + 1;
    end
    if (a == 0) return 103;
    if (a == 64) return 39;
    return a - 1;
  endfunction

  task automatic model_reset();
    foreach (mm[i]) mm[i] = -1;
    m_ac = 0; m_id = 1; m_cnt = 0; m_rd = 0;
    m_err = 0; m_disp = 0; m_cur = 0; m_blink = 0; m_two = 0;
  endtask

  task automatic model_write(int rs, int d);
    m_cnt = BS;
    if (rs != 0) begin
      mm[m_ac] = d;
      m_ac = mstep(m_ac, m_id);
    end else if (d >= 128) begin
      if (is_ddr(d - 128)) m_ac = d - 128;
      else m_err = 1;
    end else if (d >= 64) begin
      m_err = 1;
    end else if (d >= 32) begin
      m_two = (d / 8) % 2;
    end else if (d >= 16) begin
      if ((d / 8) % 2 == 0) m_ac = mstep(m_ac, (d / 4) % 2);
    end else if (d >= 8) begin
      m_disp = (d / 4) % 2; m_cur = (d / 2) % 2; m_blink = d % 2;
    end else if (d >= 4) begin
      m_id = (d / 2) % 2;
    end else if (d >= 2) begin
      m_ac = 0; m_cnt = BL;
    end else if (d == 1) begin
      foreach (mm[i]) mm[i] = -1;
      m_ac = 0; m_id = 1; m_cnt = BL;
    end else begin
      m_cnt = 0;
    end
  endtask

  task automatic push_state(int view, int rdv);
    snap_t s;
    s.ac = m_ac; s.busy = (m_cnt > 0) ? 1 : 0; s.err = m_err;
    s.disp = m_disp; s.cur = m_cur; s.blink = m_blink;
    s.two = m_two; s.view = view; s.rdv = rdv; s.rdh = m_rd;
    sq.push_back(s);
  endtask

  task automatic step(int e, int rs, int rw, int d, int va);
    int view, pre_busy, rdv;
    @(negedge clock);
    reset = 1'b1;
    bus.E = e[0]; bus.RS = rs[0]; bus.RW = rw[0];
    bus.DATA = d[7:0]; view_addr = va[6:0];
    view = mbyte(va);
    pre_busy = (m_cnt > 0) ? 1 : 0;
    rdv = 0;
    if (e != 0 && rw != 0) begin
      m_rd = (rs != 0) ? mbyte(m_ac) : pre_busy * 128 + m_ac;
      rdq.push_back(m_rd);
      rdv = 1;
    end
    if (e != 0 && rw == 0 && pre_busy == 0) begin
      model_write(rs, d);
    end else begin
      if (e != 0 && rw == 0) m_err = 1;
      if (m_cnt > 0) m_cnt--;
    end
    push_state(view, rdv);
  endtask

  task automatic do_reset(int n);
    @(negedge clock);
    reset = 1'b0;
    bus.E = 1'b0;
    model_reset();
    rdq.delete();
    #1;
    cmp("rst_busy", bus.busy, 0);
    cmp("rst_ac", ac, 0);
    cmp("rst_err", err, 0);
    cmp("rst_view", view_char, 8'h20);
    cmp("rst_rdv", bus.rd_valid, 0);
    cmp("rst_rdd", bus.rd_data, 0);
    repeat (n) begin
      push_state(32, 0);
      @(posedge clock);
    end
  endtask

  task automatic settle();
    @(posedge clock);
    #3;
  endtask

  snap_t ms;
  int    mexp;

  always @(posedge clock) begin
    #2;
    if (bus.rd_valid) begin
      if (rdq.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rd_unexpected: got rd_valid=1 want no read");
      end else begin
        mexp = rdq.pop_front();
        cmp("rd_data", bus.rd_data, mexp);
      end
    end
    if (sq.size() > 0) begin
      ms = sq.pop_front();
      cmp("ac", ac, ms.ac);
      cmp("busy", bus.busy, ms.busy);
      cmp("err", err, ms.err);
      cmp("display_on", display_on, ms.disp);
      cmp("cursor_on", cursor_on, ms.cur);
      cmp("blink_on", blink_on, ms.blink);
      cmp("two_line", two_line, ms.two);
      cmp("view_char", view_char, ms.view);
      cmp("rd_valid", bus.rd_valid, ms.rdv);
      cmp("rd_hold", bus.rd_data, ms.rdh);
    end
  end

  initial begin
    bus.E = 1'b0; bus.RS = 1'b0; bus.RW = 1'b0; bus.DATA = 8'h00;
    model_reset();
    do_reset(2);

    step(1, 0, 0, 8'h38, 0);
    step(1, 0, 0, 8'h0C, 0);
    step(1, 0, 0, 8'h06, 0);
    step(1, 1, 0, 8'h4B, 0);
    step(1, 1, 0, 8'h4F, 0);
    step(1, 1, 0, 8'h52, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, i);
    settle();
    cmp("s1_ac", ac, 7'h03);
    cmp("s1_two", two_line, 1);
    cmp("s1_disp", display_on, 1);
    cmp("s1_cur", cursor_on, 0);
    cmp("s1_view2", view_char, 8'h52);

    step(1, 0, 0, 8'hA7, 0);
    step(1, 1, 0, 8'h41, 0);
    step(0, 0, 0, 0, 8'h27);
    settle();
    cmp("s2_view27", view_char, 8'h41);
    cmp("s2_ac", ac, 7'h40);
    step(1, 0, 0, 8'h80, 0);
    step(1, 0, 0, 8'h04, 0);
    step(1, 1, 0, 8'h55, 0);
    settle();
    cmp("s2_dec_wrap", ac, 7'h67);

    step(1, 0, 0, 8'h01, 0);
    step(1, 1, 0, 8'h58, 0);
    settle();
    cmp("s3_err", err, 1);
    cmp("s3_busy", bus.busy, 1);
    step(0, 0, 0, 0, 0);
    settle();
    cmp("s3_idle", bus.busy, 0);
    for (int i = 0; i < 128; i++) step(0, 0, 0, 0, i);

    do_reset(1);
    step(1, 0, 0, 8'hC0, 0);
    step(1, 0, 1, 0, 0);
    settle();
    cmp("s4_rdv", bus.rd_valid, 1);
    cmp("s4_rd", bus.rd_data, 8'h40);
    step(1, 0, 0, 8'hA8, 0);
    settle();
    cmp("s4_ac", ac, 7'h40);
    cmp("s4_err", err, 1);

    do_reset(1);
    step(1, 0, 0, 8'hE7, 0);
    step(1, 0, 0, 8'h14, 0);
    settle();
    cmp("s5_inc_wrap", ac, 7'h00);
    step(1, 0, 0, 8'h10, 0);
    settle();
    cmp("s5_dec_wrap", ac, 7'h67);
    step(1, 0, 0, 8'h1C, 0);
    settle();
    cmp("s5_shift", ac, 7'h67);

    step(1, 1, 0, 8'h33, 0);
    step(1, 0, 0, 8'h01, 0);
    settle();
    cmp("s6_busy", bus.busy, 1);
    do_reset(1);
    for (int i = 0; i < 128; i += 7) step(0, 0, 0, 0, i);

    for (int n = 0; n < 1500; n++) begin
      int op, d, r;
      op = $urandom_range(0, 99);
      r  = $urandom_range(0, 9);
      d  = $urandom_range(0, 255);
      case (r)
        0: d = 8'h01;
        1: d = 8'h02;
        2, 3: d = 8'h80 | (d & 8'h7F);
        4: d = 8'h10 | (d & 8'h0F);
        5: d = 8'h04 | (d & 8'h03);
        6: d = 8'h08 | (d & 8'h07);
        7: d = 8'h20 | (d & 8'h1F);
        8: d = 8'h40 | (d & 8'h3F);
        default: ;
      endcase
      if (op < 1) do_reset($urandom_range(1, 2));
      else if (op < 30) step(0, 0, 0, 0, $urandom_range(0, 127));
      else if (op < 55) step(1, 1, 0, $urandom_range(0, 255),
                             $urandom_range(0, 127));
      else if (op < 82) step(1, 0, 0, d, $urandom_range(0, 127));
      else step(1, $urandom_range(0, 1), 1, 0,
                $urandom_range(0, 127));
    end

    step(0, 0, 0, 0, 0);
    @(posedge clock);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lcd_receiver.md
LCD_RECEIVER -- requirements
Module: lcd_receiver

Interface
REQ-001 Parameter BUSY_SHORT, default 0: busy cycles after a data write or a short instruction.
REQ-002 Parameter BUSY_LONG, default 2: busy cycles after clear-display or cursor-home.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  system clock; all state changes on posedge clock.
REQ-005 reset  in  1  asynchronous active-low reset.
REQ-006 E  in  1  transaction strobe, sampled at posedge clock; 1 = transaction this cycle.
REQ-007 RS  in  1  0 = instruction/status, 1 = data.
REQ-008 RW  in  1  0 = write, 1 = read.
REQ-009 DATA  in  8  write payload.
REQ-010 rd_data  out  8  read response, registered.
REQ-011 rd_valid  out  1  one-cycle pulse qualifying rd_data.
REQ-012 busy  out  1  high while the busy counter is nonzero.
REQ-013 ac  out  7  DDRAM address counter.
REQ-014 display_on, cursor_on, blink_on, two_line  out  1 each  stored control bits.
REQ-015 err  out  1  sticky error flag.
REQ-016 view_addr  in  7  DDRAM probe address.
REQ-017 view_char  out  8  DDRAM byte at view_addr, one-cycle latency.

Function
REQ-018 DDRAM SHALL be 80 bytes: line 1 at 0x00-0x27, line 2 at 0x40-0x67; every other address is invalid.
REQ-019 Each DDRAM byte SHALL carry a valid bit; reads of an invalid-bit byte SHALL return 0x20.
REQ-020 A write transaction (E=1, RW=0) arriving while busy=1 SHALL be dropped and SHALL set err.
REQ-021 A write transaction arriving while busy=0 SHALL load the busy counter:
- BUSY_LONG for clear-display and cursor-home.
- BUSY_SHORT for all other writes.
REQ-022 The busy counter SHALL decrement once per cycle down to 0.
REQ-023 Instruction decode (RS=0, RW=0) SHALL use the highest set bit of DATA:
- 0x01 clear: clear all valid bits, ac=0, id=1.
- 0x02-0x03 home: ac=0.
- 0000_01 I/D S: id=DATA[1]; S is ignored.
- 0000_1 D C B: display_on, cursor_on and blink_on load from DATA[2:0].
- 0001 S/C R/L: if S/C=0, ac steps +1 for R/L=1 or -1 for R/L=0; if S/C=1, no effect.
- 001 DL N F: two_line=DATA[3].
- 01xx_xxxx CGRAM address: no effect, set err.
- 1AAA_AAAA: ac=A if A is valid; otherwise ac is unchanged and err is set.
- 0x00: no effect and no busy.
REQ-024 A data write (RS=1, RW=0) SHALL store DATA at ac, set that byte's valid bit, then step ac by +1 if id=1 or -1 if id=0.
REQ-025 ac stepping SHALL wrap as follows:
- +1: 0x27->0x40, 0x67->0x00.
- -1: 0x00->0x67, 0x40->0x27.
REQ-026 Reads (RW=1) SHALL be accepted regardless of busy and SHALL NOT modify ac, DDRAM or the busy counter.
REQ-027 Read RS=0 SHALL return {busy, ac}; read RS=1 SHALL return the DDRAM byte at ac.
REQ-028 rd_data and rd_valid SHALL update on the cycle after the read transaction.
REQ-029 rd_data SHALL hold its value between reads.
REQ-030 For a read, busy SHALL be sampled before any same-edge update.
REQ-031 view_char SHALL equal the DDRAM byte at the previous cycle's view_addr (0x20 if the valid bit is clear or the address is invalid).
REQ-032 A data write and a view of the same address on the same edge SHALL return the old value.

Reset
REQ-033 While reset=0, the block SHALL hold: all valid bits cleared, ac=0, id=1, busy counter 0, display_on=0, cursor_on=0, blink_on=0, two_line=0, err=0, rd_data=0x00, rd_valid=0, view_char=0x20.
REQ-034 Reset asserted mid-busy or mid-transaction SHALL abort it with no residual effect.
REQ-035 err SHALL clear only on reset.

Verification
REQ-036 The bench SHALL cover these scenarios:
- Write 0x38, 0x0C, 0x06, then data 'K','O','R' -> two_line=1, display_on=1, cursor_on=0, view 0x00..0x02 = 0x4B 0x4F 0x52, ac=0x03.
- Write 0xA7, then data 0x41 -> view 0x27=0x41, ac=0x40; set id=0 at ac=0x00 and write a byte -> ac=0x67.
- With BUSY_LONG=2: write 0x01, then a data write on the next cycle -> write dropped, err=1, busy high for 2 cycles, all views 0x20.
- Write 0xC0 then read RS=0 -> rd_data=0x40 one cycle later with rd_valid pulse; write 0xA8 -> ac stays 0x40, err=1.
- Write 0x14 at ac=0x67 -> ac=0x00; write 0x10 -> ac=0x67; write 0x1C -> ac unchanged.
- Assert reset during busy -> busy=0, ac=0, err=0, all views 0x20 immediately.
